spi_master_param: RTL and testbench
===================================

Name: spi_master_param

Overview:
Synthesizable, parametrised full-duplex SPI master replacing the fixed mode-0, simulation-only master model. Frame width, sclk divider and CS setup/hold are parameters; SPI mode (CPOL/CPHA) is selected per frame at run time. User side is a valid/ready transmit port and a one-cycle receive strobe. Pins connect to the FPGA SPI slave in the loopback test bench, or to external devices.

Parameters:
FRAME_WIDTH, 16, bits per frame; legal range ≥2.
CLK_DIV, 3, sysclk cycles per sclk half-period; legal range ≥1.
CS_SETUP, 1, sclk half-periods from cs falling to the first sclk edge; legal range ≥1.
CS_HOLD, 1, sclk half-periods from the last sclk edge to cs rising; legal range ≥1.
MSB_FIRST, 1, 1 = MSB shifted first, 0 = LSB first; applies to both mosi and miso.

Ports:
sysclk  in  1  system clock.
rst_n  in  1  asynchronous reset, active low.
i_tx_valid  in  1  frame offered.
o_tx_ready  out  1  master can accept a frame.
i_tx_data  in  FRAME_WIDTH  frame to send.
i_mode  in  2  {CPOL,CPHA}; sampled only on accept.
o_rx_valid  out  1  one-cycle strobe: o_rx_data is valid.
o_rx_data  out  FRAME_WIDTH  received frame; holds its value until the next strobe.
o_busy  out  1  high whenever the FSM is not in IDLE.
miso  in  1  serial input from slave.
cs  out  1  chip select, active low.
sclk  out  1  serial clock.
mosi  out  1  serial output.

Behaviour:
- Reset, asynchronous:
  - cs=1, sclk=0, mosi=0.
  - o_tx_ready=1, o_rx_valid=0, o_rx_data=0, o_busy=0.
  - Latched mode = 0; FSM = IDLE.
  - Reset asserted mid-frame aborts the frame immediately: cs goes high in the same instant and no o_rx_valid is produced.
- Accept happens when i_tx_valid & o_tx_ready on a rising sysclk edge. On accept:
  - Latch i_tx_data and i_mode.
  - sclk <= CPOL.
  - Go to SETUP; cs low from the next cycle.
- tick: divider counter runs 0..CLK_DIV-1 in SETUP, XFER and HOLD; tick = (count == CLK_DIV-1). The counter restarts at 0 on every state entry.
- FSM, states IDLE, SETUP, XFER, HOLD:
  - IDLE: o_tx_ready=1; cs=1; sclk = latched CPOL.
  - SETUP: lasts CS_SETUP ticks. If CPHA=0, mosi presents the first bit on entry.
  - XFER: every tick toggles sclk, giving exactly 2*FRAME_WIDTH edges. Edge 1 is the leading edge.
    - CPHA=0: sample miso on leading edges; shift mosi on trailing edges, except after the final edge.
    - CPHA=1: shift mosi on leading edges (first bit on edge 1); sample miso on trailing edges.
    - After the final edge sclk = CPOL; go to HOLD.
  - HOLD: lasts CS_HOLD ticks, mosi unchanged. On exit:
    - cs=1.
    - o_rx_data updated and o_rx_valid=1 for one cycle.
    - Go to IDLE.
- Exact latency: accept at cycle T, o_rx_valid and cs rising at cycle T+1+(CS_SETUP+2*FRAME_WIDTH+CS_HOLD)*CLK_DIV.
- Back-to-back: i_tx_valid held high gives cs high for exactly 1 sysclk between frames.
- i_mode and i_tx_data changes while o_busy=1 are ignored.
- The miso bit count equals the mosi bit count; there are no partial frames.

Optional Feature:
Macro SPI_MASTER_BURST_EN.
- With macro: adds input i_tx_last (1 bit), latched on accept, and state WAIT.
  - After XFER of a frame with last=0, skip HOLD. Pulse o_rx_valid, enter WAIT: cs stays low, sclk=CPOL, o_tx_ready=1, o_busy=1.
  - Accept in WAIT goes directly to XFER after one tick. i_mode is ignored in WAIT; the mode stays fixed for the whole burst.
  - Frame with last=1 ends through HOLD as normal.
- Without macro: port absent; every frame behaves as last=1.

Test Plan:
1. FRAME_WIDTH=8, CLK_DIV=2, mode 0, tx 0xA5, slave model returns 0x3C -> mosi sampled on rising edges = 1010_0101; o_rx_data=0x3C; o_rx_valid at T+37; cs low T+1..T+36.
2. Same stimulus, mode 3 -> sclk idles high; slave samples on rising edges and sees 0xA5; o_rx_data=0x3C; identical latency.
3. Mode 1, then mode 2 back-to-back with i_tx_valid held high (0x0F, then 0xF0) -> cs high exactly 1 cycle between frames; sclk idle level switches during that cycle; both frames loop back correctly.
4. MSB_FIRST=0, tx 0x01 -> first mosi bit = 1, remaining seven = 0.
5. Assert rst_n low at sclk edge 7 -> cs=1 and sclk=0 immediately; no o_rx_valid; next frame after release completes normally.
6. With SPI_MASTER_BURST_EN: three frames with last=0,0,1 -> cs low continuously across all frames; three o_rx_valid pulses; cs rises CS_HOLD*CLK_DIV cycles after the third frame's final edge.

Source files
------------

// File: rtl/spi_master_param.sv
// spi_master_param: parametrised full-duplex SPI master with run-time CPOL/CPHA.
// Frame width, sclk divider, cs setup/hold and bit order are parameters.
// Optional burst mode (cs held low across frames, i_tx_last port, WAIT state)
// is enabled by defining SPI_MASTER_BURST_EN.
module spi_master_param #(
    parameter int FRAME_WIDTH = 16,
    parameter int CLK_DIV     = 3,
    parameter int CS_SETUP    = 1,
    parameter int CS_HOLD     = 1,
    parameter int MSB_FIRST   = 1
) (
    input  logic                   sysclk,
    input  logic                   rst_n,
    input  logic                   i_tx_valid,
    output logic                   o_tx_ready,
    input  logic [FRAME_WIDTH-1:0] i_tx_data,
    input  logic [1:0]             i_mode,
`ifdef SPI_MASTER_BURST_EN
    input  logic                   i_tx_last,
`endif
    output logic                   o_rx_valid,
    output logic [FRAME_WIDTH-1:0] o_rx_data,
    output logic                   o_busy,
    input  logic                   miso,
    output logic                   cs,
    output logic                   sclk,
    output logic                   mosi
);

    localparam int CW    = $clog2(CLK_DIV + 1);
    localparam int EDGES = 2 * FRAME_WIDTH;
    localparam int HW    = $clog2(EDGES + CS_SETUP + CS_HOLD + 1);

    typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, WAIT} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [HW-1:0]          hcnt_q, hcnt_d;
    logic [1:0]             mode_q, mode_d;
    logic [FRAME_WIDTH-1:0] tx_sh_q, tx_sh_d;
    logic [FRAME_WIDTH-1:0] rx_sh_q, rx_sh_d;
    logic [FRAME_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   cs_q, cs_d;
    logic                   sclk_q, sclk_d;
    logic                   mosi_q, mosi_d;
`ifdef SPI_MASTER_BURST_EN
    logic                   last_q, last_d;
    logic                   short_q, short_d;
`endif

    logic          tick, accept, lead, sample, final_edge, ld_cpha;
    logic [HW-1:0] setup_last;

    function automatic logic first_bit(input logic [FRAME_WIDTH-1:0] v);
        return (MSB_FIRST != 0) ? v[FRAME_WIDTH-1] : v[0];
    endfunction

    function automatic logic [FRAME_WIDTH-1:0] shift_out(input logic [FRAME_WIDTH-1:0] v);
        return (MSB_FIRST != 0) ? {v[FRAME_WIDTH-2:0], 1'b0} : {1'b0, v[FRAME_WIDTH-1:1]};
    endfunction

    function automatic logic [FRAME_WIDTH-1:0] shift_in(input logic [FRAME_WIDTH-1:0] v,
                                                         input logic b);
        return (MSB_FIRST != 0) ? {v[FRAME_WIDTH-2:0], b} : {b, v[FRAME_WIDTH-1:1]};
    endfunction

`ifdef SPI_MASTER_BURST_EN
    assign o_tx_ready = (state_q == IDLE) || (state_q == WAIT);
    // A frame accepted inside a burst waits a single tick before shifting.
    assign setup_last = short_q ? '0 : HW'(CS_SETUP - 1);
`else
    assign o_tx_ready = (state_q == IDLE);
    assign setup_last = HW'(CS_SETUP - 1);
`endif

    assign accept     = i_tx_valid & o_tx_ready;
    assign tick       = (cnt_q == CW'(CLK_DIV - 1));
    // hcnt counts completed sclk edges in XFER; even count means the next edge leads.
    assign lead       = ~hcnt_q[0];
    assign sample     = lead ^ mode_q[0];
    assign final_edge = (hcnt_q == HW'(EDGES - 1));
    // Inside a burst the mode is frozen, so the phase for loading comes from the latch.
    assign ld_cpha    = (state_q == IDLE) ? i_mode[0] : mode_q[0];

    assign o_busy     = (state_q != IDLE);
    assign o_rx_valid = rx_valid_q;
    assign o_rx_data  = rx_data_q;
    assign cs         = cs_q;
    assign sclk       = sclk_q;
    assign mosi       = mosi_q;

    // Next-state, divider and shift-register logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        hcnt_d     = hcnt_q;
        mode_d     = mode_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        cs_d       = cs_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
`ifdef SPI_MASTER_BURST_EN
        last_d     = last_q;
        short_d    = short_q;
`endif
        // State changes only happen on a tick, so the wrap restarts the count on entry.
        if (state_q inside {SETUP, XFER, HOLD})
            cnt_d = tick ? '0 : cnt_q + CW'(1);

        case (state_q)
            IDLE: begin
                hcnt_d = '0;
                if (accept) begin
                    mode_d  = i_mode;
                    sclk_d  = i_mode[1];
                    cs_d    = 1'b0;
                    state_d = SETUP;
`ifdef SPI_MASTER_BURST_EN
                    last_d  = i_tx_last;
                    short_d = 1'b0;
`endif
                end
            end
            SETUP: begin
                if (tick) begin
                    if (hcnt_q == setup_last) begin
                        hcnt_d  = '0;
                        state_d = XFER;
                    end else begin
                        hcnt_d = hcnt_q + HW'(1);
                    end
                end
            end
            XFER: begin
                if (tick) begin
                    sclk_d = ~sclk_q;
                    hcnt_d = hcnt_q + HW'(1);
                    if (sample) begin
                        rx_sh_d = shift_in(rx_sh_q, miso);
                    end else if (!final_edge) begin
                        mosi_d  = first_bit(tx_sh_q);
                        tx_sh_d = shift_out(tx_sh_q);
                    end
                    if (final_edge) begin
                        hcnt_d  = '0;
                        sclk_d  = mode_q[1];
                        state_d = HOLD;
`ifdef SPI_MASTER_BURST_EN
                        if (!last_q) begin
                            state_d    = WAIT;
                            rx_data_d  = rx_sh_d;
                            rx_valid_d = 1'b1;
                        end
`endif
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    if (hcnt_q == HW'(CS_HOLD - 1)) begin
                        hcnt_d     = '0;
                        state_d    = IDLE;
                        cs_d       = 1'b1;
                        rx_data_d  = rx_sh_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        hcnt_d = hcnt_q + HW'(1);
                    end
                end
            end
`ifdef SPI_MASTER_BURST_EN
            WAIT: begin
                hcnt_d = '0;
                if (accept) begin
                    state_d = SETUP;
                    last_d  = i_tx_last;
                    short_d = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        // Load the frame; with CPHA=0 the first bit must already sit on mosi.
        if (accept) begin
            rx_sh_d = '0;
            if (!ld_cpha) begin
                mosi_d  = first_bit(i_tx_data);
                tx_sh_d = shift_out(i_tx_data);
            end else begin
                tx_sh_d = i_tx_data;
            end
        end
    end

    // State and datapath registers; reset aborts any frame and raises cs at once.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            hcnt_q     <= '0;
            mode_q     <= 2'b00;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            cs_q       <= 1'b1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
`ifdef SPI_MASTER_BURST_EN
            last_q     <= 1'b1;
            short_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hcnt_q     <= hcnt_d;
            mode_q     <= mode_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            cs_q       <= cs_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
`ifdef SPI_MASTER_BURST_EN
            last_q     <= last_d;
            short_q    <= short_d;
`endif
        end
    end

endmodule

// File: tb/tb_spi_master_param.sv
// Bench for spi_master_param: an SPI slave model sampled on sysclk, latency and
// loopback checks for all modes, back-to-back frames, LSB-first, reset abort,
// and (with SPI_MASTER_BURST_EN) a three-frame burst.
module tb_spi_master_param;

    localparam int FW  = 8;
    localparam int CD  = 2;
    localparam int CSS = 1;
    localparam int CSH = 1;
    localparam int LAT = 1 + (CSS + 2 * FW + CSH) * CD;

    logic          sysclk = 1'b0;
    logic          rst_n  = 1'b0;
    logic          tx_valid, sel;
    logic [FW-1:0] tx_data;
    logic [1:0]    tx_mode;
`ifdef SPI_MASTER_BURST_EN
    logic          tx_last;
`endif
    logic          miso_s = 1'b0;

    logic          rdy_a, rxv_a, busy_a, cs_a, sclk_a, mosi_a;
    logic          rdy_b, rxv_b, busy_b, cs_b, sclk_b, mosi_b;
    logic [FW-1:0] rxd_a, rxd_b;
    logic          val_a, val_b;

    assign val_a = tx_valid & ~sel;
    assign val_b = tx_valid & sel;

    logic          rdy_m, rxv_m, busy_m, cs_m, sclk_m, mosi_m;
    logic [FW-1:0] rxd_m;
    assign rdy_m  = sel ? rdy_b  : rdy_a;
    assign rxv_m  = sel ? rxv_b  : rxv_a;
    assign busy_m = sel ? busy_b : busy_a;
    assign cs_m   = sel ? cs_b   : cs_a;
    assign sclk_m = sel ? sclk_b : sclk_a;
    assign mosi_m = sel ? mosi_b : mosi_a;
    assign rxd_m  = sel ? rxd_b  : rxd_a;

    spi_master_param #(.FRAME_WIDTH(FW), .CLK_DIV(CD), .CS_SETUP(CSS), .CS_HOLD(CSH),
                       .MSB_FIRST(1)) u_a (
        .sysclk(sysclk), .rst_n(rst_n), .i_tx_valid(val_a), .o_tx_ready(rdy_a),
        .i_tx_data(tx_data), .i_mode(tx_mode),
`ifdef SPI_MASTER_BURST_EN
        .i_tx_last(tx_last),
`endif
        .o_rx_valid(rxv_a), .o_rx_data(rxd_a), .o_busy(busy_a), .miso(miso_s),
        .cs(cs_a), .sclk(sclk_a), .mosi(mosi_a));

    spi_master_param #(.FRAME_WIDTH(FW), .CLK_DIV(CD), .CS_SETUP(CSS), .CS_HOLD(CSH),
                       .MSB_FIRST(0)) u_b (
        .sysclk(sysclk), .rst_n(rst_n), .i_tx_valid(val_b), .o_tx_ready(rdy_b),
        .i_tx_data(tx_data), .i_mode(tx_mode),
`ifdef SPI_MASTER_BURST_EN
        .i_tx_last(tx_last),
`endif
        .o_rx_valid(rxv_b), .o_rx_data(rxd_b), .o_busy(busy_b), .miso(miso_s),
        .cs(cs_b), .sclk(sclk_b), .mosi(mosi_b));

    always #5 sysclk = ~sysclk;

    int cyc = 0;
    always @(posedge sysclk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge sysclk);
        #1;
    endtask

    // ---------------- SPI slave model ----------------
    logic [1:0]    s_mode = 2'b00;
    logic [FW-1:0] rep_q[$];
    logic [FW-1:0] got_q[$];
    logic [FW-1:0] cur = '0, word = '0, seq = '0;
    int            sk = 0, rk = 0, edge_n = 0, last_edge_cyc = 0, rise_cyc = 0;
    bit            cs_prev = 1'b1, sclk_prev = 1'b0, lead_s;

    function automatic logic sbit(input logic [FW-1:0] w, input int k, input bit msb);
        return msb ? w[FW-1-k] : w[k];
    endfunction

    task automatic next_word();
        sk = 0;
        if (rep_q.size() != 0) cur = rep_q.pop_front();
    endtask

    always @(negedge sysclk) begin
        if (cs_prev && !cs_m) begin
            cur = (rep_q.size() != 0) ? rep_q.pop_front() : '0;
            sk = 0; rk = 0; edge_n = 0; word = '0;
            if (!s_mode[0]) miso_s = sbit(cur, 0, !sel);
        end else if (!cs_m && (sclk_m != sclk_prev)) begin
            edge_n++;
            last_edge_cyc = cyc;
            lead_s = (sclk_m != s_mode[1]);
            if (lead_s ^ s_mode[0]) begin
                seq = {seq[FW-2:0], mosi_m};
                if (!sel) word[FW-1-rk] = mosi_m;
                else      word[rk] = mosi_m;
                rk++;
                if (rk == FW) begin
                    got_q.push_back(word);
                    word = '0;
                    rk = 0;
                end
            end else if (!s_mode[0]) begin
                sk++;
                if (sk == FW) next_word();
                miso_s = sbit(cur, sk, !sel);
            end else begin
                miso_s = sbit(cur, sk, !sel);
                sk++;
                if (sk == FW) next_word();
            end
        end
        if (!cs_prev && cs_m) rise_cyc = cyc;
        cs_prev   = cs_m;
        sclk_prev = sclk_m;
    end

    // ---------------- stimulus helpers ----------------
    task automatic start(input logic [FW-1:0] d, input logic [1:0] m,
                         input logic [FW-1:0] reply, output int t);
        tx_data  = d;
        tx_mode  = m;
        s_mode   = m;
        rep_q.push_back(reply);
        got_q.delete();
        tx_valid = 1'b1;
        for (int i = 0; i < 200 && !rdy_m; i++) step();
        chk("start_ready", rdy_m, 1'b1);
        t = cyc;
    endtask

    task automatic wait_done(input int t, input logic [FW-1:0] exp_rx,
                             input logic [FW-1:0] exp_tx, input logic [1:0] m,
                             input bit keep);
        int  csl;
        bit  done;
        csl  = 0;
        done = 1'b0;
        step();
        if (!keep) tx_valid = 1'b0;
        chk("cs_low_first", cs_m, 1'b0);
        chk("sclk_setup", sclk_m, m[1]);
        chk("busy", busy_m, 1'b1);
        if (!cs_m) csl++;
        for (int i = 0; i < 400 && !done; i++) begin
            step();
            if (rxv_m) done = 1'b1;
            else if (!cs_m) csl++;
        end
        chk("rx_seen", done, 1'b1);
        chk("latency", cyc - t, LAT);
        chk("cs_low_cycles", csl, LAT - 1);
        chk("cs_high_end", cs_m, 1'b1);
        chk("rx_data", rxd_m, exp_rx);
        chk("slave_words", got_q.size(), 1);
        chk("slave_rx", (got_q.size() != 0) ? got_q[0] : ~exp_tx, exp_tx);
        chk("edges", edge_n, 2 * FW);
        chk("cs_hold", rise_cyc - last_edge_cyc, CSH * CD);
        chk("sclk_idle", sclk_m, m[1]);
    endtask

`ifdef SPI_MASTER_BURST_EN
    logic [FW-1:0] bd[3], br[3], brx[3];
    logic [1:0]    bm;
    int            pulses;
    bit            started, ended;
`endif

    int            t0, t1, seen;
    logic [FW-1:0] rd, rr;
    logic [1:0]    rm;

    initial begin
        tx_valid = 1'b0; sel = 1'b0; tx_data = '0; tx_mode = 2'b00;
`ifdef SPI_MASTER_BURST_EN
        tx_last = 1'b1;
`endif
        repeat (3) step();
        chk("rst_cs", cs_a, 1'b1);
        chk("rst_sclk", sclk_a, 1'b0);
        chk("rst_mosi", mosi_a, 1'b0);
        chk("rst_ready", rdy_a, 1'b1);
        chk("rst_rxv", rxv_a, 1'b0);
        chk("rst_rxd", rxd_a, 8'h00);
        chk("rst_busy", busy_a, 1'b0);
        rst_n = 1'b1;
        step();

        // Mode 0 and mode 3 with the fixed pattern.
        start(8'hA5, 2'd0, 8'h3C, t0);
        wait_done(t0, 8'h3C, 8'hA5, 2'd0, 1'b0);
        chk("mode0_mosi_seq", seq, 8'hA5);
        step();
        start(8'hA5, 2'd3, 8'h3C, t0);
        wait_done(t0, 8'h3C, 8'hA5, 2'd3, 1'b0);
        chk("mode3_sclk_idle_hi", sclk_a, 1'b1);
        step();

        // Back-to-back: mode 1 then mode 2 with valid held high.
        start(8'h0F, 2'd1, 8'h96, t0);
        wait_done(t0, 8'h96, 8'h0F, 2'd1, 1'b1);
        chk("b2b_gap_sclk_old", sclk_a, 1'b0);
        chk("b2b_gap_ready", rdy_a, 1'b1);
        start(8'hF0, 2'd2, 8'h69, t1);
        chk("b2b_gap_len", t1 - t0, LAT);
        wait_done(t1, 8'h69, 8'hF0, 2'd2, 1'b0);
        step();

        // LSB-first instance.
        sel = 1'b1;
        step();
        start(8'h01, 2'd0, 8'hC3, t0);
        wait_done(t0, 8'hC3, 8'h01, 2'd0, 1'b0);
        chk("lsb_mosi_seq", seq, 8'h80);
        for (int i = 0; i < 2; i++) begin
            rd = FW'($urandom); rr = FW'($urandom); rm = 2'($urandom_range(0, 3));
            step();
            start(rd, rm, rr, t0);
            wait_done(t0, rr, rd, rm, 1'b0);
        end
        step();
        sel = 1'b0;
        step();

        // Randomized frames on the MSB-first instance.
        for (int i = 0; i < 6; i++) begin
            rd = FW'($urandom); rr = FW'($urandom); rm = 2'($urandom_range(0, 3));
            start(rd, rm, rr, t0);
            wait_done(t0, rr, rd, rm, 1'b0);
            step();
        end

        // Reset in the middle of a frame.
        start(8'h5A, 2'd1, 8'hE7, t0);
        step();
        tx_valid = 1'b0;
        for (int i = 0; i < 300 && edge_n < 7; i++) step();
        chk("rst_reach_edge7", edge_n, 7);
        chk("rst_sclk_before", sclk_a, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("abort_cs", cs_a, 1'b1);
        chk("abort_sclk", sclk_a, 1'b0);
        seen = 0;
        repeat (3) begin step(); if (rxv_a) seen++; end
        rst_n = 1'b1;
        repeat (60) begin step(); if (rxv_a) seen++; end
        chk("abort_no_rxv", seen, 0);
        chk("abort_idle", busy_a, 1'b0);
        rep_q.delete();
        rd = FW'($urandom); rr = FW'($urandom);
        start(rd, 2'd0, rr, t0);
        wait_done(t0, rr, rd, 2'd0, 1'b0);
        step();

`ifdef SPI_MASTER_BURST_EN
        // Burst of three frames, last = 0,0,1; i_mode changes must be ignored.
        bm = 2'($urandom_range(0, 3));
        for (int i = 0; i < 3; i++) begin
            bd[i] = FW'($urandom); br[i] = FW'($urandom); brx[i] = '0;
            rep_q.push_back(br[i]);
        end
        got_q.delete();
        s_mode = bm; tx_mode = bm; tx_data = bd[0]; tx_last = 1'b0; tx_valid = 1'b1;
        pulses = 0; started = 1'b0; ended = 1'b0;
        for (int i = 0; i < 2000 && !ended; i++) begin
            step();
            if (rxv_a) begin
                if (pulses < 3) brx[pulses] = rxd_a;
                pulses++;
                if (pulses < 3) begin
                    tx_data = bd[pulses];
                    tx_last = (pulses == 2);
                    tx_mode = ~bm;
                end else begin
                    tx_valid = 1'b0;
                end
            end
            if (!cs_a) started = 1'b1;
            else if (started) ended = 1'b1;
        end
        chk("burst_ended", ended, 1'b1);
        chk("burst_pulses", pulses, 3);
        for (int i = 0; i < 3; i++) begin
            chk("burst_rx", brx[i], br[i]);
            chk("burst_slave", (got_q.size() > i) ? got_q[i] : ~bd[i], bd[i]);
        end
        chk("burst_edges", edge_n, 3 * 2 * FW);
        chk("burst_hold", rise_cyc - last_edge_cyc, CSH * CD);
        tx_last = 1'b1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
